branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and branch/mispredict statistics.
// Lookup is combinational on registered state; updates land on the rising edge.
module branch_predictor #(
    parameter int ENTRIES = 32,
    parameter int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_if,
    input  logic        i_update_en,
    input  logic [31:0] i_pc_ex,
    input  logic        i_taken_ex,
    input  logic [31:0] i_target_ex,
    input  logic        i_mispred_ex,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_pc,
    output logic        o_btb_hit,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt
);
    localparam int TAG_W = 32 - INDEX_W - 2;

    logic             valid_arr  [ENTRIES];
    logic [TAG_W-1:0] tag_arr    [ENTRIES];
    logic [31:0]      target_arr [ENTRIES];
    logic [1:0]       ctr_arr    [ENTRIES];

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [1:0]         upd_ctr;
    logic [1:0]         ctr_next;

    logic [31:0] branch_cnt_reg;
    logic [31:0] mispred_cnt_reg;

    assign lk_idx  = i_pc_if[INDEX_W+1:2];
    assign lk_tag  = i_pc_if[31:INDEX_W+2];
    assign upd_idx = i_pc_ex[INDEX_W+1:2];
    assign upd_tag = i_pc_ex[31:INDEX_W+2];

    assign o_btb_hit    = valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
    assign o_pred_taken = o_btb_hit && ctr_arr[lk_idx][1];
    assign o_pred_pc    = o_pred_taken ? target_arr[lk_idx] : (i_pc_if + 32'd4);

    assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
    assign upd_ctr = ctr_arr[upd_idx];

    // A miss only reaches an entry when taken, so the default is the allocation value.
    always_comb begin
        ctr_next = 2'b10;
        if (upd_hit) begin
            if (i_taken_ex)
                ctr_next = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
            else
                ctr_next = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : entry_g
            logic             valid_reg;
            logic [1:0]       ctr_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      target_reg;
            logic             wr_sel;

            assign wr_sel = i_update_en && (upd_idx == INDEX_W'(gi)) && (upd_hit || i_taken_ex);

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b01;
                end else if (wr_sel) begin
                    valid_reg <= 1'b1;
                    ctr_reg   <= ctr_next;
                end
            end

            // Tag/target need no reset: they are only meaningful once valid is set.
            always_ff @(posedge i_clk) begin
                if (wr_sel && i_taken_ex) begin
                    tag_reg    <= upd_tag;
                    target_reg <= i_target_ex;
                end
            end

            assign valid_arr[gi]  = valid_reg;
            assign ctr_arr[gi]    = ctr_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            branch_cnt_reg  <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else if (i_update_en) begin
            branch_cnt_reg <= branch_cnt_reg + 32'd1;
            if (i_mispred_ex)
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
        end
    end

    assign o_branch_cnt  = branch_cnt_reg;
    assign o_mispred_cnt = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a behavioural BTB model.
module tb_branch_predictor;
    localparam int ENTRIES = 32;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_pc_if = 32'd0;
    logic        i_update_en = 1'b0;
    logic [31:0] i_pc_ex = 32'd0;
    logic        i_taken_ex = 1'b0;
    logic [31:0] i_target_ex = 32'd0;
    logic        i_mispred_ex = 1'b0;
    logic        o_pred_taken;
    logic [31:0] o_pred_pc;
    logic        o_btb_hit;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_if(i_pc_if), .i_update_en(i_update_en),
        .i_pc_ex(i_pc_ex), .i_taken_ex(i_taken_ex), .i_target_ex(i_target_ex),
        .i_mispred_ex(i_mispred_ex), .o_pred_taken(o_pred_taken), .o_pred_pc(o_pred_pc),
        .o_btb_hit(o_btb_hit), .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int passes = 0;

    // Reference model: per-slot branch record keyed by PC, strength as an integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_pc    [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_str   [ENTRIES];
    int unsigned m_bc;
    int unsigned m_mc;

    function automatic int slot(input int unsigned pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit same_branch(input int unsigned a, input int unsigned b);
        return (a / (ENTRIES * 4)) == (b / (ENTRIES * 4));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_str[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_update(input int unsigned pc, input bit taken,
                                input int unsigned tgt, input bit mis);
        int s;
        s = slot(pc);
        m_bc++;
        if (mis) m_mc++;
        if (m_valid[s] && same_branch(m_pc[s], pc)) begin
            if (taken) begin
                m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
                m_tgt[s] = tgt;
            end else begin
                m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[s] = 1'b1;
            m_pc[s]    = pc;
            m_tgt[s]   = tgt;
            m_str[s]   = 2;
        end
    endtask

    // One cycle: drive inputs just after the edge, predict the lookup, then advance the model.
    task automatic step(input int unsigned pc_if, input bit upd, input int unsigned pc_ex,
                        input bit taken, input int unsigned tgt, input bit mis, input bit rst_n);
        exp_t e;
        int s;
        @(posedge i_clk);
        #1;
        i_pc_if      = pc_if;
        i_update_en  = upd;
        i_pc_ex      = pc_ex;
        i_taken_ex   = taken;
        i_target_ex  = tgt;
        i_mispred_ex = mis;
        i_reset      = rst_n;
        if (!rst_n) model_reset();
        s = slot(pc_if);
        e.hit   = m_valid[s] && same_branch(m_pc[s], pc_if);
        e.taken = e.hit && (m_str[s] >= 2);
        e.pc    = e.taken ? m_tgt[s] : pc_if + 32'd4;
        e.bc    = m_bc;
        e.mc    = m_mc;
        sb_q.push_back(e);
        if (rst_n && upd) model_update(pc_ex, taken, tgt, mis);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("btb_hit",     32'(o_btb_hit),    32'(e.hit));
                chk("pred_taken",  32'(o_pred_taken), 32'(e.taken));
                chk("pred_pc",     o_pred_pc,         e.pc);
                chk("branch_cnt",  o_branch_cnt,      e.bc);
                chk("mispred_cnt", o_mispred_cnt,     e.mc);
                $display("txn pc_if=%h hit=%0b taken=%0b pred_pc=%h bc=%0d mc=%0d",
                         i_pc_if, o_btb_hit, o_pred_taken, o_pred_pc, o_branch_cnt, o_mispred_cnt);
            end
        end
    end

    function automatic int unsigned rand_pc();
        int unsigned pc;
        if ($urandom_range(0, 9) == 0) pc = $urandom() & 32'hFFFF_FFFC;
        else pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
        return pc;
    endfunction

    initial begin : driver
        int budget;
        model_reset();
        step(32'h100, 1, 32'h100, 1, 32'h200, 1, 0);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        // Allocate, then see the prediction and statistics.
        step(32'h100, 1, 32'h100, 1, 32'h200, 1, 1);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        // Saturating decrement from strong-ish to strongly not-taken.
        for (int i = 0; i < 3; i++) step(32'h100, 1, 32'h100, 0, 0, 0, 1);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        // Alias: same slot, different tag replaces the entry.
        step(32'h100, 1, 32'h100, 1, 32'h200, 0, 1);
        step(32'h180, 1, 32'h180, 1, 32'h300, 1, 1);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        step(32'h180, 0, 0, 0, 0, 0, 1);
        // Not-taken at an unallocated PC changes nothing but the branch count.
        step(32'h400, 1, 32'h400, 0, 32'h999, 0, 1);
        step(32'h400, 0, 0, 0, 0, 0, 1);
        // Same-cycle lookup/update: weak not-taken entry becomes taken next cycle.
        step(32'h100, 1, 32'h100, 1, 32'h200, 0, 1);
        step(32'h100, 1, 32'h100, 0, 0, 0, 1);
        step(32'h100, 1, 32'h100, 1, 32'h240, 0, 1);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        // Reset asserted between edges with an update pending; the update must be dropped.
        step(32'h100, 1, 32'h100, 1, 32'h200, 1, 0);
        step(32'h100, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            step(rand_pc(), ($urandom_range(0, 3) != 0), rand_pc(), $urandom_range(0, 1),
                 $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1), ($urandom_range(0, 60) != 0));
        end
        step(32'h100, 0, 0, 0, 0, 0, 1);
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge i_clk);
            budget--;
        end
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
